// File: rtl/alu.sv
// alu: registered 16-bit arithmetic/logic unit feeding the write-back mux and high-result register.
// Latency: 1 cycle, inputs sampled at edge N are visible on outputs after edge N.
// Backpressure: none, accepts one operation every cycle with no stall.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   rst          synchronous active-high reset, clears all outputs
//   data1        operand A, also the value shifted/rotated
//   data2        operand B, only [3:0] used as amount for shifts/rotates
//   op           4-bit opcode
//   upper        high half of the 32-bit result (product high / remainder)
//   lower        low half of the result
//   zero         {exception, lower==0}; exception = signed overflow on ADD/SUB,
//                or divide-by-zero / 8000/FFFF overflow on DIV
//
// Optional feature: define ALU_DIV_EN to build the single-cycle signed divider
// for op 4'h5; otherwise op 4'h5 behaves like a reserved opcode.
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  input  logic [3:0]  op,
  output logic [15:0] upper,
  output logic [15:0] lower,
  output logic [1:0]  zero
);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_MUL = 4'h4;
  localparam logic [3:0] OP_DIV = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_SLL = 4'h8;
  localparam logic [3:0] OP_SRL = 4'h9;
  localparam logic [3:0] OP_ROL = 4'hA;
  localparam logic [3:0] OP_ROR = 4'hB;

  logic [15:0] sum;
  logic [15:0] diff;
  logic [31:0] prod;
  logic [3:0]  shamt;
  logic [4:0]  shinv;
  logic [15:0] nxt_upper;
  logic [15:0] nxt_lower;
  logic        nxt_exc;

  assign sum   = data1 + data2;
  assign diff  = data1 - data2;
  assign prod  = $signed(data1) * $signed(data2);
  assign shamt = data2[3:0];
  // Complementary amount for the wrap-around half of a rotate. With shamt=0
  // it is 16, which shifts a 16-bit value fully out, so rotate-by-0 is a pass.
  assign shinv = 5'd16 - {1'b0, shamt};

`ifdef ALU_DIV_EN
  logic [15:0] quot;
  logic [15:0] rem;
  logic        div_by_zero;
  logic        div_ovf;

  assign div_by_zero = (data2 == 16'h0000);
  // -32768 / -1 is the only quotient that does not fit in 16 bits.
  assign div_ovf     = (data1 == 16'h8000) && (data2 == 16'hFFFF);

  // Native signed division truncates toward zero and gives the remainder the
  // sign of the dividend. The two special cases are muxed around it so the
  // divider result is never used when it would be undefined.
  always_comb begin
    quot = 16'h0000;
    rem  = 16'h0000;
    if (div_by_zero) begin
      quot = 16'hFFFF;
      rem  = data1;
    end else if (div_ovf) begin
      quot = 16'h8000;
      rem  = 16'h0000;
    end else begin
      quot = $signed(data1) / $signed(data2);
      rem  = $signed(data1) % $signed(data2);
    end
  end
`endif

  always_comb begin
    nxt_upper = 16'h0000;
    nxt_lower = 16'h0000;
    nxt_exc   = 1'b0;
    case (op)
      OP_ADD: begin
        nxt_lower = sum;
        // Overflow when both operands share a sign and the result does not.
        nxt_exc   = (data1[15] == data2[15]) && (sum[15] != data1[15]);
      end
      OP_SUB: begin
        nxt_lower = diff;
        // Overflow when operand signs differ and the result takes B's sign.
        nxt_exc   = (data1[15] != data2[15]) && (diff[15] != data1[15]);
      end
      OP_AND: nxt_lower = data1 & data2;
      OP_OR:  nxt_lower = data1 | data2;
      OP_MUL: begin
        nxt_upper = prod[31:16];
        nxt_lower = prod[15:0];
      end
`ifdef ALU_DIV_EN
      OP_DIV: begin
        nxt_upper = rem;
        nxt_lower = quot;
        nxt_exc   = div_by_zero || div_ovf;
      end
`endif
      OP_XOR: nxt_lower = data1 ^ data2;
      OP_NOT: nxt_lower = ~data1;
      OP_SLL: nxt_lower = data1 << shamt;
      OP_SRL: nxt_lower = data1 >> shamt;
      OP_ROL: nxt_lower = (data1 << shamt) | (data1 >> shinv);
      OP_ROR: nxt_lower = (data1 >> shamt) | (data1 << shinv);
      default: begin
        // Reserved opcodes (and DIV when the divider is not built) produce 0.
        nxt_upper = 16'h0000;
        nxt_lower = 16'h0000;
        nxt_exc   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      upper <= 16'h0000;
      lower <= 16'h0000;
      zero  <= 2'b00;
    end else begin
      upper <= nxt_upper;
      lower <= nxt_lower;
      zero  <= {nxt_exc, (nxt_lower == 16'h0000)};
    end
  end

endmodule

// File: tb/tb_alu.sv
module tb_alu;

  logic        clk;
  logic        rst;
  logic [15:0] data1;
  logic [15:0] data2;
  logic [3:0]  op;
  logic [15:0] upper;
  logic [15:0] lower;
  logic [1:0]  zero;

  int n_checks;
  int n_pass;

  logic [33:0] exp_v;
  logic [33:0] got_v;

  alu dut (
    .clk   (clk),
    .rst   (rst),
    .data1 (data1),
    .data2 (data2),
    .op    (op),
    .upper (upper),
    .lower (lower),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: works on plain integers, packs {zero, upper, lower}.
  function automatic logic [33:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] o);
    int sa, sb, r, q, rm;
    logic [15:0] up, lo, t;
    logic ex;
    sa = $signed(a);
    sb = $signed(b);
    up = 16'h0000;
    lo = 16'h0000;
    ex = 1'b0;
    case (o)
      4'h0: begin r = sa + sb; lo = r[15:0]; ex = (r > 32767) || (r < -32768); end
      4'h1: begin r = sa - sb; lo = r[15:0]; ex = (r > 32767) || (r < -32768); end
      4'h2: lo = a & b;
      4'h3: lo = a | b;
      4'h4: begin r = sa * sb; up = r[31:16]; lo = r[15:0]; end
`ifdef ALU_DIV_EN
      4'h5: begin
        if (sb == 0) begin
          lo = 16'hFFFF; up = a; ex = 1'b1;
        end else begin
          q = sa / sb;
          rm = sa % sb;
          lo = q[15:0];
          up = rm[15:0];
          ex = (q > 32767);
        end
      end
`endif
      4'h6: lo = a ^ b;
      4'h7: lo = ~a;
      4'h8: lo = a << b[3:0];
      4'h9: lo = a >> b[3:0];
      4'hA: begin
        t = a;
        for (int i = 0; i < int'(b[3:0]); i++) t = {t[14:0], t[15]};
        lo = t;
      end
      4'hB: begin
        t = a;
        for (int i = 0; i < int'(b[3:0]); i++) t = {t[0], t[15:1]};
        lo = t;
      end
      default: begin up = 16'h0000; lo = 16'h0000; ex = 1'b0; end
    endcase
    return {ex, (lo == 16'h0000), up, lo};
  endfunction

  // Drive one operation away from the active edge, then sample after it.
  task automatic step(input logic [15:0] a, input logic [15:0] b, input logic [3:0] o);
    @(negedge clk);
    data1 = a;
    data2 = b;
    op    = o;
    @(posedge clk);
    #1;
    got_v = {zero, upper, lower};
  endtask

  task automatic test_reset;
    rst = 1'b1;
    data1 = 16'h1234; data2 = 16'h0001; op = 4'h4;
    repeat (2) @(posedge clk);
    #1;
    got_v = {zero, upper, lower};
    n_checks++;
    if (got_v !== 34'h0) $display("FAIL reset_state: got %h expected %h", got_v, 34'h0);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [15:0] ta [14];
    logic [15:0] tb [14];
    logic [3:0]  to [14];
    logic [33:0] te [14];
    ta = '{16'h000F, 16'h7FFF, 16'h0A00, 16'h1234, 16'h00FF, 16'h00FF, 16'h7FFF,
           16'hFFFF, 16'h8000, 16'h00FF, 16'h8001, 16'h8001, 16'hFFFF, 16'h5555};
    tb = '{16'h0001, 16'h0001, 16'h00F0, 16'h1234, 16'hF0F0, 16'h0004, 16'h0002,
           16'h0002, 16'h0001, 16'h0000, 16'h0001, 16'h0001, 16'h0000, 16'h1111};
    to = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h9, 4'h9, 4'h4,
           4'h4, 4'h1, 4'h8, 4'hA, 4'hB, 4'hC, 4'hF};
    // Hand-written expectations: {zero, upper, lower}.
    te = '{{2'b00, 16'h0000, 16'h0010}, {2'b10, 16'h0000, 16'h8000},
           {2'b00, 16'h0000, 16'h0910}, {2'b01, 16'h0000, 16'h0000},
           {2'b00, 16'h0000, 16'h00FF}, {2'b00, 16'h0000, 16'h000F},
           {2'b00, 16'h0000, 16'hFFFE}, {2'b00, 16'hFFFF, 16'hFFFE},
           {2'b10, 16'h0000, 16'h7FFF}, {2'b00, 16'h0000, 16'h00FF},
           {2'b00, 16'h0000, 16'h0003}, {2'b00, 16'h0000, 16'hC000},
           {2'b01, 16'h0000, 16'h0000}, {2'b01, 16'h0000, 16'h0000}};
    for (int i = 0; i < 14; i++) begin
      step(ta[i], tb[i], to[i]);
      n_checks++;
      if (got_v !== te[i])
        $display("FAIL directed_%0d op=%h: got %h expected %h", i, to[i], got_v, te[i]);
      else n_pass++;
    end
  endtask

  task automatic test_div;
`ifdef ALU_DIV_EN
    logic [15:0] ta [5];
    logic [15:0] tb [5];
    logic [33:0] te [5];
    ta = '{16'h0007, 16'h0007, 16'h8000, 16'hFFF9, 16'h0007};
    tb = '{16'h0002, 16'h0000, 16'hFFFF, 16'h0002, 16'hFFFE};
    te = '{{2'b00, 16'h0001, 16'h0003}, {2'b10, 16'h0007, 16'hFFFF},
           {2'b10, 16'h0000, 16'h8000}, {2'b00, 16'hFFFF, 16'hFFFD},
           {2'b00, 16'h0001, 16'hFFFD}};
`else
    logic [15:0] ta [2];
    logic [15:0] tb [2];
    logic [33:0] te [2];
    ta = '{16'h0007, 16'h0007};
    tb = '{16'h0002, 16'h0000};
    te = '{{2'b01, 16'h0000, 16'h0000}, {2'b01, 16'h0000, 16'h0000}};
`endif
    for (int i = 0; i < $size(ta); i++) begin
      step(ta[i], tb[i], 4'h5);
      n_checks++;
      if (got_v !== te[i])
        $display("FAIL div_%0d: got %h expected %h", i, got_v, te[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random;
    logic [15:0] a, b;
    logic [3:0]  o;
    for (int i = 0; i < 400; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      o = 4'($urandom_range(0, 15));
      if (i % 8 == 0) b = 16'h0000;
      if (i % 13 == 0) a = 16'h8000;
      step(a, b, o);
      exp_v = ref_model(a, b, o);
      n_checks++;
      if (got_v !== exp_v)
        $display("FAIL random_%0d a=%h b=%h op=%h: got %h expected %h", i, a, b, o, got_v, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    logic [33:0] held;
    logic [15:0] a, b;
    logic [3:0]  o;
    for (int i = 0; i < 20; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      o = 4'($urandom_range(0, 11));
      step(a, b, o);
      held = ref_model(a, b, o);
      // Disturb inputs mid-cycle; registered outputs must not move.
      #2;
      data1 = ~a; data2 = ~b; op = o ^ 4'h3;
      #1;
      got_v = {zero, upper, lower};
      n_checks++;
      if (got_v !== held)
        $display("FAIL hold_%0d: got %h expected %h", i, got_v, held);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midstream;
    step(16'h0003, 16'h0004, 4'h4);
    @(negedge clk);
    rst = 1'b1;
    data1 = 16'h000F; data2 = 16'h0001; op = 4'h0;
    @(posedge clk);
    #1;
    got_v = {zero, upper, lower};
    n_checks++;
    if (got_v !== 34'h0) $display("FAIL reset_mid: got %h expected %h", got_v, 34'h0);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    got_v = {zero, upper, lower};
    n_checks++;
    if (got_v !== {2'b00, 16'h0000, 16'h0010})
      $display("FAIL reset_release: got %h expected %h", got_v, {2'b00, 16'h0000, 16'h0010});
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    rst = 1'b1;
    data1 = 16'h0000;
    data2 = 16'h0000;
    op = 4'h0;
    test_reset;
    test_directed;
    test_div;
    test_random;
    test_back_to_back;
    test_reset_midstream;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
